layer_compositor: RTL
=====================

# layer_compositor

Parametrised, pipelined pixel compositor and pixel-accurate collision detector for the VGA game display. It takes NUM_LAYERS sprite layers (bounding box plus a colour already fetched from that layer's ROM for the current scan pixel) and selects the highest-priority opaque colour. It also accumulates per-frame player-versus-obstacle overlap and latches it at frame boundaries. It sits between the sprite/ROM address logic and the `rgb` output pins, replacing hand-written priority chains and box-only collision tests.

## Interface
Parameters:
- NUM_LAYERS, 8, number of layers (2..16); layer 0 is the player and has the highest priority, priority falls with index
- RGB_W, 12, colour width
- COORD_W, 10, pixel coordinate width
- KEY_COLOR, 0, transparent colour value
- BG_COLOR, 12'h200, colour output where no layer is opaque
- BLANK_COLOR, 12'h020, colour output when video is off

Ports:
- system_clk  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- pixel_x, pixel_y  in  COORD_W each  current scan coordinate
- video_on  in  1  active-video flag aligned with pixel_x/pixel_y
- frame_start  in  1  one-cycle pulse on the first pixel of a frame
- freeze  in  1  pause/game-over hold; suppresses collision accumulation
- layer_en  in  NUM_LAYERS  per-layer display enable
- collide_mask  in  NUM_LAYERS  layer k counts as an obstacle when bit k is 1 (bit 0 is ignored)
- layer_l, layer_r, layer_t, layer_b  in  NUM_LAYERS*COORD_W  inclusive box edges; layer k occupies slice [k*COORD_W +: COORD_W]
- layer_rgb  in  NUM_LAYERS*RGB_W  layer colours, aligned with pixel_x/pixel_y
- collide_clr  in  1  clears the collide_sticky flag
- rgb_out  out  RGB_W  composited colour
- video_on_out  out  1  video_on delayed to align with rgb_out
- hit_mask  out  NUM_LAYERS  obstacles hit in the last completed frame (bit 0 is always 0)
- hit_valid  out  1  one-cycle pulse when hit_mask updates
- collide_sticky  out  1  set by any frame with a hit; held until cleared

## Operation
- Layer k is opaque at the current pixel when all of the following hold:
  - layer_en[k] is 1
  - l ≤ pixel_x ≤ r and t ≤ pixel_y ≤ b (unsigned compares)
  - layer_rgb[k] ≠ KEY_COLOR
- A layer with l > r or t > b is never opaque.
- Stage 1 registers, for every layer: the opaque flag and its colour. It also registers video_on and frame_start.
- Stage 2 drives rgb_out as follows:
  - BLANK_COLOR if the delayed video_on is 0
  - otherwise the colour of the lowest-index opaque layer
  - otherwise BG_COLOR
- Collision uses the stage-1 flags:
  - hit_now[k] = opq[0] & opq[k] & collide_mask[k] & video_on_d1 & ~freeze_d1, for k ≥ 1
  - hit_acc |= hit_now on every cycle
- Frame latch, in the cycle where frame_start_d1 = 1:
  - hit_mask ← hit_acc
  - hit_acc ← hit_now; that pixel belongs to the new frame
  - on the next cycle hit_valid = 1, and collide_sticky is set if hit_mask ≠ 0
- collide_sticky:
  - clears on collide_clr
  - if a set and a clear occur in the same cycle, set wins
- freeze affects collision only; compositing continues normally.
- Two frame_start pulses on consecutive cycles: the second latch captures only the first pixel's hit_now.

## Timing
- Latency from pixel inputs to rgb_out / video_on_out: exactly 2 cycles.
- Throughput: one pixel per cycle, no stalls.
- frame_start to hit_mask update: 2 cycles; to hit_valid and collide_sticky: 3 cycles.
- Reset (asynchronous, reset_n = 0) forces the following; the pipeline refills 2 cycles after release:
  - all pipeline registers to 0
  - rgb_out = 0, video_on_out = 0
  - hit_mask = 0, hit_valid = 0, collide_sticky = 0, hit_acc = 0
- A reset in the middle of a frame discards the partial hit_acc. The first latch after reset reports only pixels seen since the release.
- layer_* and collide_mask are sampled every cycle and may change at any time; each pixel uses the values present on its own input cycle.

## Test plan
- Priority: NUM_LAYERS=4; layers 0 and 2 opaque at (100,100) with colours 12'hF00 and 12'h0F0; video_on=1 -> rgb_out = 12'hF00 exactly 2 cycles later. Set layer_rgb[0]=KEY_COLOR -> 12'h0F0. Disable all layers -> BG_COLOR 12'h200.
- Blanking: video_on=0 while layers are opaque -> rgb_out = 12'h020 and video_on_out = 0 with 2-cycle latency.
- Collision: layer 0 box (50..60,50..60) and layer 1 box (58..70,55..65), both opaque, collide_mask=4'b0010; scan a frame, then pulse frame_start -> hit_mask=4'b0010 2 cycles later, hit_valid pulses 1 cycle after that, collide_sticky=1. With collide_mask bit 1 = 0 -> hit_mask=0.
- Transparency: the same overlap but layer 1's colour is KEY_COLOR in the overlap region -> hit_mask=0, collide_sticky stays 0.
- freeze: freeze=1 over a whole frame that contains an overlap -> hit_mask=0. Assert collide_clr in the same cycle as a set -> collide_sticky remains 1; collide_clr alone -> 0.
- Reset mid-frame: accumulate a hit, pull reset_n low asynchronously between clock edges -> all outputs 0 immediately. After release, a clean frame latches hit_mask=0.

Source files
------------

// File: rtl/layer_compositor.sv
// Two-stage sprite layer compositor with pixel-accurate player/obstacle collision.
// Stage 1 resolves per-layer opacity, stage 2 picks the colour and maintains frame hit state.
module layer_compositor #(
  parameter int              NUM_LAYERS  = 8,
  parameter int              RGB_W       = 12,
  parameter int              COORD_W     = 10,
  parameter logic [RGB_W-1:0] KEY_COLOR   = '0,
  parameter logic [RGB_W-1:0] BG_COLOR    = 12'h200,
  parameter logic [RGB_W-1:0] BLANK_COLOR = 12'h020
) (
  input  logic                          system_clk,
  input  logic                          reset_n,
  input  logic [COORD_W-1:0]            pixel_x,
  input  logic [COORD_W-1:0]            pixel_y,
  input  logic                          video_on,
  input  logic                          frame_start,
  input  logic                          freeze,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [NUM_LAYERS-1:0]         collide_mask,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_l,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_r,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_t,
  input  logic [NUM_LAYERS*COORD_W-1:0] layer_b,
  input  logic [NUM_LAYERS*RGB_W-1:0]   layer_rgb,
  input  logic                          collide_clr,
  output logic [RGB_W-1:0]              rgb_out,
  output logic                          video_on_out,
  output logic [NUM_LAYERS-1:0]         hit_mask,
  output logic                          hit_valid,
  output logic                          collide_sticky
);

  // Stage 1 registers
  logic [NUM_LAYERS-1:0]       opq_d, opq_q;
  logic [NUM_LAYERS*RGB_W-1:0] col_q;
  logic [NUM_LAYERS-1:0]       mask_d1_q;
  logic                        video_d1_q, fs_d1_q, freeze_d1_q;

  // Stage 2 / frame registers
  logic [RGB_W-1:0]      rgb_d, rgb_q;
  logic                  video_d2_q;
  logic [NUM_LAYERS-1:0] hit_now, acc_d, acc_q, hit_mask_q;
  logic                  fs_d2_q, hit_valid_q, sticky_d, sticky_q;

  // An inverted box (l > r or t > b) fails these compares naturally.
  always_comb begin
    opq_d = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      opq_d[k] = layer_en[k]
              && (pixel_x >= layer_l[k*COORD_W +: COORD_W])
              && (pixel_x <= layer_r[k*COORD_W +: COORD_W])
              && (pixel_y >= layer_t[k*COORD_W +: COORD_W])
              && (pixel_y <= layer_b[k*COORD_W +: COORD_W])
              && (layer_rgb[k*RGB_W +: RGB_W] != KEY_COLOR);
    end
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      opq_q       <= '0;
      col_q       <= '0;
      mask_d1_q   <= '0;
      video_d1_q  <= 1'b0;
      fs_d1_q     <= 1'b0;
      freeze_d1_q <= 1'b0;
    end else begin
      opq_q       <= opq_d;
      col_q       <= layer_rgb;
      mask_d1_q   <= collide_mask;
      video_d1_q  <= video_on;
      fs_d1_q     <= frame_start;
      freeze_d1_q <= freeze;
    end
  end

  // Walk from lowest priority upward so layer 0 overrides everything.
  always_comb begin
    rgb_d = BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (opq_q[k]) rgb_d = col_q[k*RGB_W +: RGB_W];
    end
    if (!video_d1_q) rgb_d = BLANK_COLOR;
  end

  always_comb begin
    hit_now    = opq_q & mask_d1_q & {NUM_LAYERS{opq_q[0] & video_d1_q & ~freeze_d1_q}};
    hit_now[0] = 1'b0;
    // The frame_start pixel already belongs to the new frame.
    acc_d      = fs_d1_q ? hit_now : (acc_q | hit_now);
    sticky_d   = sticky_q;
    if (collide_clr)                      sticky_d = 1'b0;
    if (fs_d2_q && (hit_mask_q != '0))    sticky_d = 1'b1;
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q       <= '0;
      video_d2_q  <= 1'b0;
      acc_q       <= '0;
      hit_mask_q  <= '0;
      fs_d2_q     <= 1'b0;
      hit_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      video_d2_q  <= video_d1_q;
      acc_q       <= acc_d;
      if (fs_d1_q) hit_mask_q <= acc_q;
      fs_d2_q     <= fs_d1_q;
      hit_valid_q <= fs_d2_q;
      sticky_q    <= sticky_d;
    end
  end

  assign rgb_out        = rgb_q;
  assign video_on_out   = video_d2_q;
  assign hit_mask       = hit_mask_q;
  assign hit_valid      = hit_valid_q;
  assign collide_sticky = sticky_q;

endmodule
